// File: rtl/phase_ramp_gen.sv
// Phase ramp generator: streams Q16.16 angles in [0, 2*pi) built from a
// programmable start offset plus a per-beat step, wrapped modulo 2*pi.
// Configuration arrives over a valid/ready handshake; the angle stream
// honours full backpressure and runs either as a finite burst or continuously.
module phase_ramp_gen #(
  parameter logic [31:0] TWO_PI = 32'd411775,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [31:0]      cfg_step,
  input  logic [31:0]      cfg_offset,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic [31:0]      x,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [31:0]      step_q;
  logic [31:0]      offset_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      x_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_err_q;
  logic             cfg_ready_q;

  logic             beat_d;
  logic [31:0]      x_adv_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             last_d;
  logic             cfg_bad_d;

  // Modulo-2*pi add: both operands are already below TWO_PI, so a single
  // conditional subtract of the 33-bit sum always lands back in range.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, TWO_PI}) begin
      wrap_add = s[31:0] - TWO_PI;
    end else begin
      wrap_add = s[31:0];
    end
  endfunction

  // Beat detection, next angle, burst-end detection and config validity.
  always_comb begin
    beat_d    = x_valid_q & x_ready;
    x_adv_d   = wrap_add(x_q, step_q);
    cnt_inc_d = cnt_q + CNT_W'(1);
    last_d    = (count_q != {CNT_W{1'b0}}) && (cnt_inc_d == count_q);
    cfg_bad_d = (cfg_step >= TWO_PI) || (cfg_offset >= TWO_PI);
  end

  // Control FSM with config storage and registered stream/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 32'd0;
      offset_q    <= 32'd0;
      count_q     <= {CNT_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      x_q         <= 32'd0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid && cfg_ready_q) begin
            if (cfg_bad_d) begin
              cfg_err_q <= 1'b1;
            end else begin
              step_q   <= cfg_step;
              offset_q <= cfg_offset;
              count_q  <= cfg_count;
            end
          end
          // The burst launches from the previously stored offset, so a
          // config accepted on this same edge only affects later bursts.
          if (start && !stop) begin
            state_q     <= ST_RUN;
            x_q         <= offset_q;
            x_valid_q   <= 1'b1;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort; a beat taken on this edge still counts and advances x.
            state_q     <= ST_IDLE;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            if (beat_d) begin
              x_q   <= x_adv_d;
              cnt_q <= cnt_inc_d;
            end
          end else if (beat_d) begin
            cnt_q <= cnt_inc_d;
            if (last_d) begin
              // Final beat: x keeps the last transferred angle.
              state_q   <= ST_DONE;
              x_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              x_q <= x_adv_d;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          x_valid_q   <= 1'b0;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_phase_ramp_gen.sv
// Self-checking bench for phase_ramp_gen: directed scenarios plus randomized
// bursts with random backpressure, checked against an arithmetic model
// angle(k) = (offset + k*step) mod 2*pi.
module tb_phase_ramp_gen;

  localparam logic [31:0] TWO_PI = 32'd411775;
  localparam int          CNT_W  = 16;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [31:0]      cfg_step;
  logic [31:0]      cfg_offset;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic [31:0]      x;
  logic             x_valid;
  logic             x_ready;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;

  // Model of stored configuration
  logic [31:0]      m_step;
  logic [31:0]      m_off;
  logic [CNT_W-1:0] m_cnt;
  bit               exp_err;

  // Collector results
  logic [31:0] got_q[$];
  int          done_seen;
  int          stall_bad;
  int          stall_cycles;
  bit          timed_out;
  bit          done_bad;
  bit          done_after_bad;
  logic [31:0] x_at_done;

  phase_ramp_gen #(.TWO_PI(TWO_PI), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_offset (cfg_offset),
    .cfg_count  (cfg_count),
    .cfg_err    (cfg_err),
    .start      (start),
    .stop       (stop),
    .x          (x),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_angle(input logic [31:0] off, input logic [31:0] st, input int k);
    longint unsigned v;
    v = (longint'(off) + longint'(k) * longint'(st)) % longint'(TWO_PI);
    return v[31:0];
  endfunction

  task automatic load_cfg(input logic [31:0] s, input logic [31:0] o, input logic [CNT_W-1:0] c);
    cfg_valid  = 1'b1;
    cfg_step   = s;
    cfg_offset = o;
    cfg_count  = c;
    @(negedge clk);
    cfg_valid  = 1'b0;
    exp_err = (s >= TWO_PI) || (o >= TWO_PI);
    if (!exp_err) begin
      m_step = s;
      m_off  = o;
      m_cnt  = c;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive x_ready each cycle and record every transferred angle until done.
  task automatic collect(input int max_cyc, input bit rnd, input logic [63:0] stall_mask);
    logic [31:0] prev_x;
    bit          prev_stall;
    got_q.delete();
    done_seen = 0; stall_bad = 0; stall_cycles = 0;
    timed_out = 1'b1; done_bad = 1'b0; done_after_bad = 1'b0;
    prev_stall = 1'b0; prev_x = 32'd0; x_at_done = 32'd0;
    for (int i = 0; i < max_cyc; i++) begin
      if (prev_stall && (x_valid !== 1'b1 || x !== prev_x)) stall_bad++;
      if (done === 1'b1) begin
        done_seen++;
        x_at_done = x;
        if (x_valid !== 1'b0 || busy !== 1'b0) done_bad = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (x_valid !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (rnd) x_ready = ($urandom_range(0, 3) != 0);
      else     x_ready = (i < 64) ? !stall_mask[i] : 1'b1;
      if (x_ready) got_q.push_back(x);
      else         stall_cycles++;
      prev_stall = !x_ready;
      prev_x     = x;
      @(negedge clk);
    end
    x_ready = 1'b1;
    @(negedge clk);
    if (done !== 1'b0 || cfg_ready !== 1'b1 || x_valid !== 1'b0) done_after_bad = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_step = 32'd0; m_off = 32'd0; m_cnt = '0;
    n_tests++;
    if (x !== 32'd0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got x=%0d xv=%0b busy=%0b done=%0b err=%0b rdy=%0b exp 0 0 0 0 0 1",
               x, x_valid, busy, done, cfg_err, cfg_ready);
    end
  endtask

  task automatic test_burst();
    logic [31:0] exp_v [8];
    exp_v = '{32'd0, 32'd65536, 32'd131072, 32'd196608, 32'd262144, 32'd327680, 32'd393216, 32'd46977};
    load_cfg(32'd65536, 32'd0, 16'd8);
    pulse_start();
    n_tests++;
    if (x_valid !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0 || x !== 32'd0) begin
      n_fail++;
      $display("FAIL burst_first got xv=%0b busy=%0b rdy=%0b x=%0d exp 1 1 0 0", x_valid, busy, cfg_ready, x);
    end
    collect(50, 1'b0, 64'd0);
    n_tests++;
    if (got_q.size() != 8 || timed_out || done_seen != 1) begin
      n_fail++;
      $display("FAIL burst_len got beats=%0d done=%0d to=%0b exp 8 1 0", got_q.size(), done_seen, timed_out);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_q[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL burst_beat%0d got %0d exp %0d", i, got_q[i], exp_v[i]);
        end
      end
    end
    n_tests++;
    if (done_bad || done_after_bad || x_at_done !== 32'd46977) begin
      n_fail++;
      $display("FAIL burst_done got bad=%0b after_bad=%0b x=%0d exp 0 0 46977", done_bad, done_after_bad, x_at_done);
    end
  endtask

  task automatic test_wrap();
    load_cfg(32'd1, 32'd411774, 16'd3);
    pulse_start();
    collect(50, 1'b0, 64'd0);
    n_tests++;
    if (got_q.size() != 3 || done_seen != 1) begin
      n_fail++;
      $display("FAIL wrap_len got %0d exp 3", got_q.size());
    end else if (got_q[0] !== 32'd411774 || got_q[1] !== 32'd0 || got_q[2] !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_vals got %0d,%0d,%0d exp 411774,0,1", got_q[0], got_q[1], got_q[2]);
    end
  endtask

  task automatic test_backpressure();
    load_cfg(32'd65536, 32'd0, 16'd4);
    pulse_start();
    // ready low for three cycles while x shows the second angle
    collect(50, 1'b0, 64'h000000000000000E);
    n_tests++;
    if (stall_cycles != 3 || stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall got stalls=%0d unstable=%0d exp 3 0", stall_cycles, stall_bad);
    end
    n_tests++;
    if (got_q.size() != 4 || done_seen != 1 || done_after_bad) begin
      n_fail++;
      $display("FAIL bp_len got beats=%0d done=%0d exp 4 1", got_q.size(), done_seen);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got_q[i] !== exp_angle(32'd0, 32'd65536, i)) begin
          n_fail++;
          $display("FAIL bp_beat%0d got %0d exp %0d", i, got_q[i], exp_angle(32'd0, 32'd65536, i));
        end
      end
    end
  endtask

  task automatic test_rejected_cfg();
    load_cfg(32'd65536, 32'd100, 16'd2);
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_ok_err got %0b exp 0", cfg_err);
    end
    load_cfg(32'd458752, 32'd5, 16'd9);
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_bad_err got %0b exp 1", cfg_err);
    end
    @(negedge clk);
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_pulse got %0b exp 0", cfg_err);
    end
    pulse_start();
    collect(50, 1'b0, 64'd0);
    n_tests++;
    if (got_q.size() != 2 || done_seen != 1) begin
      n_fail++;
      $display("FAIL cfg_keep_len got %0d exp 2", got_q.size());
    end else if (got_q[0] !== 32'd100 || got_q[1] !== 32'd65636) begin
      n_fail++;
      $display("FAIL cfg_keep_vals got %0d,%0d exp 100,65636", got_q[0], got_q[1]);
    end
  endtask

  task automatic test_stop();
    load_cfg(32'd12345, 32'd7, 16'd0);
    pulse_start();
    x_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    n_tests++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_state got xv=%0b busy=%0b done=%0b rdy=%0b exp 0 0 0 1", x_valid, busy, done, cfg_ready);
    end
    n_tests++;
    if (x !== exp_angle(32'd7, 32'd12345, 5)) begin
      n_fail++;
      $display("FAIL stop_x got %0d exp %0d", x, exp_angle(32'd7, 32'd12345, 5));
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || x_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_nodone got done=%0b xv=%0b exp 0 0", done, x_valid);
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || x_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_stop_idle got busy=%0b xv=%0b rdy=%0b exp 0 0 1", busy, x_valid, cfg_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    load_cfg(32'd1000, 32'd500, 16'd0);
    pulse_start();
    x_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (x !== 32'd2500) begin
      n_fail++;
      $display("FAIL rst_pre_x got %0d exp 2500", x);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_step = 32'd0; m_off = 32'd0; m_cnt = '0;
    n_tests++;
    if (x !== 32'd0 || x_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got x=%0d xv=%0b busy=%0b rdy=%0b done=%0b exp 0 0 0 1 0",
               x, x_valid, busy, cfg_ready, done);
    end
    pulse_start();
    @(negedge clk);
    n_tests++;
    if (x !== 32'd0 || x_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_cleared_cfg got x=%0d xv=%0b exp 0 1", x, x_valid);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_tests++;
    if (x_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cleared_stop got xv=%0b busy=%0b exp 0 0", x_valid, busy);
    end
  endtask

  task automatic test_random();
    int          bad_vals;
    bit          bad;
    logic [31:0] s;
    logic [31:0] o;
    for (int it = 0; it < 12; it++) begin
      if (it == 0 || $urandom_range(0, 2) == 0) begin
        bad = (it != 0) && ($urandom_range(0, 3) == 0);
        s = bad ? $urandom_range(32'd411775, 32'hFFFFFFFF) : $urandom_range(0, 32'd411774);
        o = $urandom_range(0, 32'd411774);
        load_cfg(s, o, CNT_W'($urandom_range(1, 12)));
        n_tests++;
        if (cfg_err !== exp_err) begin
          n_fail++;
          $display("FAIL rand_cfg_err it=%0d got %0b exp %0b", it, cfg_err, exp_err);
        end
      end
      pulse_start();
      collect(400, 1'b1, 64'd0);
      n_tests++;
      if (got_q.size() != int'(m_cnt) || done_seen != 1 || timed_out || stall_bad != 0 || done_after_bad) begin
        n_fail++;
        $display("FAIL rand_burst it=%0d got beats=%0d done=%0d to=%0b unstable=%0d exp beats=%0d done=1",
                 it, got_q.size(), done_seen, timed_out, stall_bad, m_cnt);
      end
      bad_vals = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i] !== exp_angle(m_off, m_step, i)) bad_vals++;
      end
      n_tests++;
      if (bad_vals != 0) begin
        n_fail++;
        $display("FAIL rand_vals it=%0d got %0d wrong angles exp 0 (step=%0d off=%0d)", it, bad_vals, m_step, m_off);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_step = 32'd0; cfg_offset = 32'd0; cfg_count = '0;
    start = 1'b0; stop = 1'b0; x_ready = 1'b1;
    m_step = 32'd0; m_off = 32'd0; m_cnt = '0; exp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_wrap();
    test_backpressure();
    test_rejected_cfg();
    test_stop();
    test_start_stop_idle();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
